instruction_loader: RTL and testbench

INSTRUCTION_LOADER -- requirements
Module: instruction_loader

---
 rtl/instruction_loader.sv | 189 ++++++++++++++++++
 tb/tb_instruction_loader.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_loader.sv
// instruction_loader
//   Receives a big-endian byte stream, packs it into 32-bit instruction words
//   and writes them to consecutive word addresses of an instruction memory.
//
//   Optional feature macro: LOADER_CHECKSUM_EN. When defined, one extra byte
//   is taken after the last word and compared to the XOR of all data bytes.
//   A mismatch raises Error until the next accepted Start or Reset.
//
//   Ports:
//     Clk, Reset        clock, asynchronous active-high reset
//     Start, WordCount  load request (sampled in IDLE) and word count
//     ByteIn, ByteValid byte stream input
//     ByteReady         loader can take a byte this cycle
//     WrEnable          one-cycle memory write strobe
//     WrAddress/WrData  byte address (word aligned) and data of the write
//     Busy, Done, Error status; Done is a one-cycle completion pulse
//     dbg_state         current FSM state, for debug/checkers
//
//   Handshake: a byte transfers on a rising edge where ByteValid and
//   ByteReady are both 1. ByteReady does not depend on ByteValid, and a
//   producer holds ByteIn stable while ByteValid is high and not yet taken.
module instruction_loader #(
    parameter int MEM_DEPTH = 1024
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [10:0] WordCount,
    input  logic [7:0]  ByteIn,
    input  logic        ByteValid,
    output logic        ByteReady,
    output logic        WrEnable,
    output logic [31:0] WrAddress,
    output logic [31:0] WrData,
    output logic        Busy,
    output logic        Done,
    output logic        Error,
    output logic [2:0]  dbg_state
);

    // Wide enough to hold MEM_DEPTH itself (index reaches count at the end).
    localparam int CW = $clog2(MEM_DEPTH + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RECV  = 3'd1,
        S_WRITE = 3'd2,
`ifdef LOADER_CHECKSUM_EN
        S_CHECK = 3'd3,
`endif
        S_DONE  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] index_q, index_d;
    logic [1:0]    byte_cnt_q, byte_cnt_d;
    logic [23:0]   word_q, word_d;      // first three bytes of the current word
    logic [31:0]   wr_addr_q, wr_addr_d;
    logic [31:0]   wr_data_q, wr_data_d;
    logic [31:0]   wc_clamped;
    logic          byte_take;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0]    csum_q, csum_d;
    logic          error_q, error_d;
`endif

    assign wc_clamped = ({21'd0, WordCount} > 32'(MEM_DEPTH)) ? 32'(MEM_DEPTH)
                                                              : {21'd0, WordCount};

`ifdef LOADER_CHECKSUM_EN
    assign ByteReady = (state_q == S_RECV) || (state_q == S_CHECK);
    assign Error     = error_q;
`else
    assign ByteReady = (state_q == S_RECV);
    assign Error     = 1'b0;
`endif
    assign byte_take = ByteValid && ByteReady;
    assign WrEnable  = (state_q == S_WRITE);
    assign Busy      = (state_q != S_IDLE);
    assign Done      = (state_q == S_DONE);
    assign WrAddress = wr_addr_q;
    assign WrData    = wr_data_q;
    assign dbg_state = state_q;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        index_d    = index_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d     = csum_q;
        error_d    = error_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    count_d    = CW'(wc_clamped);
                    index_d    = '0;
                    byte_cnt_d = '0;
                    word_d     = '0;
`ifdef LOADER_CHECKSUM_EN
                    csum_d     = '0;
                    error_d    = 1'b0;
`endif
                    state_d    = (wc_clamped == 32'd0) ? S_DONE : S_RECV;
                end
            end
            S_RECV: begin
                if (byte_take) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    csum_d     = csum_q ^ ByteIn;
`endif
                    if (byte_cnt_q == 2'd3) begin
                        // Word data and address update only here, so both
                        // hold steady outside WRITE.
                        wr_data_d = {word_q, ByteIn};
                        wr_addr_d = 32'(index_q) << 2;
                        state_d   = S_WRITE;
                    end else begin
                        word_d = {word_q[15:0], ByteIn};
                    end
                end
            end
            S_WRITE: begin
                index_d = index_q + CW'(1);
                if (index_q + CW'(1) == count_q) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = S_CHECK;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    state_d = S_RECV;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (byte_take) begin
                    if (ByteIn != csum_q) begin
                        error_d = 1'b1;
                    end
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            index_q    <= '0;
            byte_cnt_q <= '0;
            word_q     <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= '0;
            error_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            index_q    <= index_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
            error_q    <= error_d;
`endif
        end
    end

endmodule

// File: tb/tb_instruction_loader.sv
// tb_instruction_loader
//   Bench for instruction_loader. A reference model turns each load's byte
//   list into the expected (address, word) writes; a monitor pops them as
//   WrEnable pulses appear.
module tb_instruction_loader;

    localparam int DEPTH = 1024;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [10:0] WordCount;
    logic [7:0]  ByteIn;
    logic        ByteValid;
    logic        ByteReady;
    logic        WrEnable;
    logic [31:0] WrAddress;
    logic [31:0] WrData;
    logic        Busy;
    logic        Done;
    logic        Error;
    logic [2:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int wr_cyc = 0;
    int prev_wr_cyc = 0;
    logic [31:0] last_addr = '0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_exp;
    logic [7:0]  load_bytes[$];

    instruction_loader #(.MEM_DEPTH(DEPTH)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .WordCount (WordCount),
        .ByteIn    (ByteIn),
        .ByteValid (ByteValid),
        .ByteReady (ByteReady),
        .WrEnable  (WrEnable),
        .WrAddress (WrAddress),
        .WrData    (WrData),
        .Busy      (Busy),
        .Done      (Done),
        .Error     (Error),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard monitor ----------------
    task automatic monitor();
        forever begin
            @(negedge Clk);
            if (Reset !== 1'b1) begin
                if (WrEnable === 1'b1) begin
                    wr_cnt++;
                    prev_wr_cyc = wr_cyc;
                    wr_cyc = cyc;
                    last_addr = WrAddress;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_write: got addr=%h data=%h, required no write",
                                 WrAddress, WrData);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        if ({WrAddress, WrData} !== mon_exp) begin
                            errors++;
                            $display("FAIL write_data: got addr=%h data=%h, required addr=%h data=%h",
                                     WrAddress, WrData, mon_exp[63:32], mon_exp[31:0]);
                        end
                    end
                    checks++;
                    if (WrAddress > 32'((DEPTH - 1) * 4)) begin
                        errors++;
                        $display("FAIL addr_range: got %h, required <= %h", WrAddress, (DEPTH - 1) * 4);
                    end
                end
                if (Done === 1'b1) done_cnt++;
`ifndef LOADER_CHECKSUM_EN
                checks++;
                if (Error !== 1'b0) begin
                    errors++;
                    $display("FAIL error_tied: got %b, required 0", Error);
                end
`endif
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_start(input int wc);
        Start = 1'b1;
        WordCount = 11'(wc);
        start_cyc = cyc;
        @(negedge Clk);
        Start = 1'b0;
        WordCount = 11'($urandom);   // must not affect a captured load
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        ByteIn = b;
        ByteValid = 1'b1;
        t = 0;
        while (ByteReady !== 1'b1 && t < 100) begin
            @(negedge Clk);
            t++;
        end
        if (t >= 100) begin
            checks++;
            errors++;
            $display("FAIL byte_accept_timeout: ByteReady=%b after %0d cycles, required 1", ByteReady, t);
        end
        @(negedge Clk);
        ByteValid = 1'b0;
    endtask

    task automatic idle(input int n);
        ByteValid = 1'b0;
        repeat (n) @(negedge Clk);
    endtask

    // Reference model + full load: expected writes are word i at address
    // 4*i built from bytes 4i..4i+3, first byte most significant.
    task automatic run_load(input int wc, input int gap_after, input bit rand_gaps,
                            input bit spur, input logic [7:0] csum_flip, output int lat);
        int n;
        int w0;
        int d0;
        int t;
        logic [7:0] cs;
        n = (wc > DEPTH) ? DEPTH : wc;
        cs = 8'h00;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({32'(i * 4), load_bytes[4*i], load_bytes[4*i+1],
                             load_bytes[4*i+2], load_bytes[4*i+3]});
            for (int j = 0; j < 4; j++) cs = cs ^ load_bytes[4*i+j];
        end
        w0 = wr_cnt;
        d0 = done_cnt;
        do_start(wc);
        checks++;
        if (Busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start: got %b, required 1", Busy);
        end
`ifdef LOADER_CHECKSUM_EN
        checks++;
        if (Error !== 1'b0) begin
            errors++;
            $display("FAIL error_clear_on_start: got %b, required 0", Error);
        end
`endif
        for (int k = 0; k < 4 * n; k++) begin
            if (spur && k < 4 * n - 1) begin
                Start = 1'($urandom_range(0, 1));
                WordCount = 11'($urandom);
            end
            send_byte(load_bytes[k]);
            Start = 1'b0;
            if (k == gap_after) idle(3);
            else if (rand_gaps) idle($urandom_range(0, 2));
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(cs ^ csum_flip);
`endif
        t = 0;
        while (done_cnt == d0 && t < 200) begin
            @(posedge Clk);
            t++;
        end
        @(negedge Clk);
        checks++;
        if (done_cnt != d0 + 1) begin
            errors++;
            $display("FAIL done_count: got %0d pulses, required 1", done_cnt - d0);
        end
        checks++;
        if (wr_cnt - w0 != n) begin
            errors++;
            $display("FAIL write_count: got %0d, required %0d", wr_cnt - w0, n);
        end
        checks++;
        if (Busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_after_done: got %b, required 0", Busy);
        end
`ifdef LOADER_CHECKSUM_EN
        checks++;
        if (Error !== (csum_flip != 8'h00)) begin
            errors++;
            $display("FAIL checksum_error: got %b, required %b", Error, csum_flip != 8'h00);
        end
`endif
        lat = wr_cyc - start_cyc;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        Reset = 1'b1;
        Start = 1'b0;
        WordCount = '0;
        ByteIn = '0;
        ByteValid = 1'b0;
        repeat (2) @(negedge Clk);
        checks++;
        if ({ByteReady, WrEnable, Busy, Done, Error} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b, required 00000", {ByteReady, WrEnable, Busy, Done, Error});
        end
        checks++;
        if ({WrAddress, WrData} !== 64'd0 || dbg_state !== 3'd0) begin
            errors++;
            $display("FAIL reset_regs: got addr=%h data=%h state=%0d, required 0", WrAddress, WrData, dbg_state);
        end
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
        checks++;
        if (Busy !== 1'b0 || ByteReady !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got busy=%b ready=%b, required 0 0", Busy, ByteReady);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        load_bytes = '{8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00};
        run_load(2, -1, 1'b0, 1'b0, 8'h00, lat);
        checks++;
        if (wr_cyc - prev_wr_cyc != 5) begin
            errors++;
            $display("FAIL word_throughput: got %0d cycles, required 5", wr_cyc - prev_wr_cyc);
        end
    endtask

    task automatic test_zero_count();
        int w0;
        w0 = wr_cnt;
        do_start(0);
        checks++;
        if (Done !== 1'b1 || ByteReady !== 1'b0 || WrEnable !== 1'b0) begin
            errors++;
            $display("FAIL zero_done: got done=%b ready=%b we=%b, required 1 0 0", Done, ByteReady, WrEnable);
        end
        @(negedge Clk);
        checks++;
        if (Done !== 1'b0 || Busy !== 1'b0 || ByteReady !== 1'b0) begin
            errors++;
            $display("FAIL zero_idle: got done=%b busy=%b ready=%b, required 0 0 0", Done, Busy, ByteReady);
        end
        checks++;
        if (wr_cnt != w0) begin
            errors++;
            $display("FAIL zero_no_write: got %0d writes, required 0", wr_cnt - w0);
        end
    endtask

    task automatic test_gap_latency();
        int lat0;
        int lat1;
        load_bytes = '{8'h12, 8'h34, 8'h56, 8'h78};
        run_load(1, -1, 1'b0, 1'b0, 8'h00, lat0);
        checks++;
        if (lat0 != 5) begin
            errors++;
            $display("FAIL write_latency: got %0d cycles, required 5", lat0);
        end
        run_load(1, 1, 1'b0, 1'b0, 8'h00, lat1);
        checks++;
        if (lat1 - lat0 != 3) begin
            errors++;
            $display("FAIL gap_delay: got %0d cycles, required 3", lat1 - lat0);
        end
    endtask

    task automatic test_reset_mid_load();
        int w0;
        int lat;
        load_bytes.delete();
        for (int i = 0; i < 12; i++) load_bytes.push_back(8'($urandom));
        exp_q.push_back({32'd0, load_bytes[0], load_bytes[1], load_bytes[2], load_bytes[3]});
        w0 = wr_cnt;
        do_start(3);
        for (int k = 0; k < 6; k++) send_byte(load_bytes[k]);
        Reset = 1'b1;
        #1;
        checks++;
        if ({ByteReady, WrEnable, Busy, Done, Error} !== 5'b0 || {WrAddress, WrData} !== 64'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got flags=%b addr=%h data=%h, required 0",
                     {ByteReady, WrEnable, Busy, Done, Error}, WrAddress, WrData);
        end
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        checks++;
        if (wr_cnt - w0 != 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL reset_mid_writes: got %0d writes, required 1", wr_cnt - w0);
        end
        load_bytes.delete();
        for (int i = 0; i < 4; i++) load_bytes.push_back(8'($urandom));
        run_load(1, -1, 1'b0, 1'b0, 8'h00, lat);
        checks++;
        if (last_addr !== 32'h0) begin
            errors++;
            $display("FAIL restart_addr: got %h, required 00000000", last_addr);
        end
    endtask

    task automatic test_random();
        int wc;
        int lat;
        logic [7:0] flip;
        for (int r = 0; r < 8; r++) begin
            wc = $urandom_range(1, 6);
            load_bytes.delete();
            for (int i = 0; i < 4 * wc; i++) load_bytes.push_back(8'($urandom));
            flip = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 255)) : 8'h00;
            run_load(wc, -1, 1'b1, 1'b1, flip, lat);
        end
    endtask

    task automatic test_clamp();
        int lat;
        load_bytes.delete();
        for (int i = 0; i < 4 * DEPTH; i++) load_bytes.push_back(8'($urandom));
        run_load(2000, -1, 1'b0, 1'b0, 8'h00, lat);
        checks++;
        if (last_addr !== 32'h0000_0FFC) begin
            errors++;
            $display("FAIL clamp_last_addr: got %h, required 00000ffc", last_addr);
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        int lat;
        load_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_load(1, -1, 1'b0, 1'b0, 8'h00, lat);   // checksum byte 0x44
        run_load(1, -1, 1'b0, 1'b0, 8'h01, lat);   // checksum byte 0x45
        repeat (3) @(negedge Clk);
        checks++;
        if (Error !== 1'b1) begin
            errors++;
            $display("FAIL error_hold: got %b, required 1", Error);
        end
        run_load(1, -1, 1'b0, 1'b0, 8'h00, lat);
    endtask
`endif

    // ---------------- sequence + report ----------------
    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_back_to_back();
        test_zero_count();
        test_gap_latency();
        test_reset_mid_load();
        test_random();
        test_clamp();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        repeat (3) @(negedge Clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending writes, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
